// File: rtl/spi_frame_sequencer.sv
`timescale 1ns/1ps
// Frame sequencer in front of an SPI master driver: splits a frame into words,
// runs one driver transaction per word (MSW first) and reassembles the replies.
module spi_frame_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_WORDS  = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              frame_valid,
    input  logic [FRAME_WORDS*DATA_WIDTH-1:0] frame_in,
    output logic                              frame_ready,
    output logic [FRAME_WORDS*DATA_WIDTH-1:0] frame_out,
    output logic                              frame_out_valid,
    output logic                              frame_err,
    output logic                              busy,
    output logic                              drv_start,
    output logic [DATA_WIDTH-1:0]             drv_data_in,
    input  logic [DATA_WIDTH-1:0]             drv_data_out,
    input  logic                              drv_ready
);

    localparam int FW  = FRAME_WORDS * DATA_WIDTH;
    localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int TCW = $clog2(BUSY_TIMEOUT + 1);
    localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [FW-1:0]         tx_q, tx_d;
    logic [FW-1:0]         rx_q, rx_d;
    logic [WCW-1:0]        word_cnt_q, word_cnt_d;
    logic [TCW-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [GCW-1:0]        gap_cnt_q, gap_cnt_d;
    logic                  abort_q, abort_d;
    logic                  frame_ready_q, frame_ready_d;
    logic [FW-1:0]         frame_out_q, frame_out_d;
    logic                  frame_out_valid_q, frame_out_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  busy_q, busy_d;
    logic                  drv_start_q, drv_start_d;
    logic [DATA_WIDTH-1:0] drv_data_in_q, drv_data_in_d;
    logic [FW-1:0]         tx_next;
    logic                  accept;

    // frame_ready_q is only ever high while sitting in IDLE, so it gates acceptance alone.
    assign accept  = frame_valid & frame_ready_q;
    assign tx_next = tx_q << DATA_WIDTH;

    always_comb begin
        state_d           = state_q;
        tx_d              = tx_q;
        rx_d              = rx_q;
        word_cnt_d        = word_cnt_q;
        tmo_cnt_d         = tmo_cnt_q;
        gap_cnt_d         = gap_cnt_q;
        abort_d           = abort_q;
        frame_out_d       = frame_out_q;
        frame_out_valid_d = 1'b0;
        frame_err_d       = 1'b0;
        drv_start_d       = 1'b0;
        drv_data_in_d     = drv_data_in_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tx_d          = frame_in;
                    rx_d          = '0;
                    word_cnt_d    = WCW'(FRAME_WORDS - 1);
                    drv_data_in_d = frame_in[FW-1 -: DATA_WIDTH];
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                if (drv_ready) begin
                    drv_start_d = 1'b1;
                    tmo_cnt_d   = '0;
                    state_d     = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!drv_ready) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TCW'(1);
                    if (tmo_cnt_d == TCW'(BUSY_TIMEOUT)) begin
                        abort_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (drv_ready) begin
                    rx_d = (rx_q << DATA_WIDTH) | FW'(drv_data_out);
                    if (word_cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        word_cnt_d    = word_cnt_q - WCW'(1);
                        tx_d          = tx_next;
                        drv_data_in_d = tx_next[FW-1 -: DATA_WIDTH];
                        gap_cnt_d     = '0;
                        state_d       = (GAP_CYCLES == 0) ? S_LOAD : S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + GCW'(1);
                if (gap_cnt_d == GCW'(GAP_CYCLES)) begin
                    gap_cnt_d = '0;
                    state_d   = S_LOAD;
                end
            end
            S_DONE: begin
                // On abort, word_cnt_q+1 slices were never filled; left-align what arrived.
                frame_out_d       = abort_q ? (rx_q << (DATA_WIDTH * (int'(word_cnt_q) + 1))) : rx_q;
                frame_out_valid_d = 1'b1;
                frame_err_d       = abort_q;
                abort_d           = 1'b0;
                state_d           = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        frame_ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
        busy_d        = !frame_ready_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_IDLE;
            tx_q              <= '0;
            rx_q              <= '0;
            word_cnt_q        <= '0;
            tmo_cnt_q         <= '0;
            gap_cnt_q         <= '0;
            abort_q           <= 1'b0;
            frame_ready_q     <= 1'b0;
            frame_out_q       <= '0;
            frame_out_valid_q <= 1'b0;
            frame_err_q       <= 1'b0;
            busy_q            <= 1'b0;
            drv_start_q       <= 1'b0;
            drv_data_in_q     <= '0;
        end else begin
            state_q           <= state_d;
            tx_q              <= tx_d;
            rx_q              <= rx_d;
            word_cnt_q        <= word_cnt_d;
            tmo_cnt_q         <= tmo_cnt_d;
            gap_cnt_q         <= gap_cnt_d;
            abort_q           <= abort_d;
            frame_ready_q     <= frame_ready_d;
            frame_out_q       <= frame_out_d;
            frame_out_valid_q <= frame_out_valid_d;
            frame_err_q       <= frame_err_d;
            busy_q            <= busy_d;
            drv_start_q       <= drv_start_d;
            drv_data_in_q     <= drv_data_in_d;
        end
    end

    assign frame_ready     = frame_ready_q;
    assign frame_out       = frame_out_q;
    assign frame_out_valid = frame_out_valid_q;
    assign frame_err       = frame_err_q;
    assign busy            = busy_q;
    assign drv_start       = drv_start_q;
    assign drv_data_in     = drv_data_in_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
`timescale 1ns/1ps
// Bench for spi_frame_sequencer: three instances (gap 2, 0, 3), each with a
// complementing loopback driver model; instance 0 carries most scenarios.
module tb_spi_frame_sequencer;
  localparam int DW  = 8;
  localparam int FWD = 4;
  localparam int W   = FWD * DW;
  localparam int TMO = 4;
  localparam int NI  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  logic          fv    [NI];
  logic [W-1:0]  fin   [NI];
  logic          frdy  [NI];
  logic [W-1:0]  fout  [NI];
  logic          fov   [NI];
  logic          ferr  [NI];
  logic          busy  [NI];
  logic          dstart[NI];
  logic [DW-1:0] ddin  [NI];
  bit            force_low[NI];
  int            ign_nth  [NI];
  wire [31:0]    lgmin_w  [NI];
  wire [31:0]    lgmax_w  [NI];
  wire [31:0]    ovl_w    [NI];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GAP = (g == 0) ? 2 : ((g == 1) ? 0 : 3);
    logic          drdy;
    logic [DW-1:0] ddout;
    logic [DW-1:0] seen[$];
    int starts, last_raise, raise_any, gmin, gmax, last_gmin, last_gmax;
    int stab_viol, ign_cyc, nvalid, ovl;

    spi_frame_sequencer #(
      .DATA_WIDTH(DW), .FRAME_WORDS(FWD), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)
    ) u_dut (
      .clk(clk), .rst(rst),
      .frame_valid(fv[g]), .frame_in(fin[g]), .frame_ready(frdy[g]),
      .frame_out(fout[g]), .frame_out_valid(fov[g]), .frame_err(ferr[g]),
      .busy(busy[g]), .drv_start(dstart[g]), .drv_data_in(ddin[g]),
      .drv_data_out(ddout), .drv_ready(drdy)
    );

    assign lgmin_w[g] = last_gmin;
    assign lgmax_w[g] = last_gmax;
    assign ovl_w[g]   = ovl;

    // Driver model: drops ready after a start, holds it low 1..4 cycles,
    // then raises it with the complement of the word that was sent.
    initial begin : drv
      int cnt;
      int gap;
      logic [DW-1:0] word;
      drdy = 1'b1; ddout = '0; cnt = 0; word = '0;
      starts = 0; last_raise = -1; raise_any = 0; gmin = 1000; gmax = -1;
      last_gmin = 1000; last_gmax = -1; stab_viol = 0; ign_cyc = 0; nvalid = 0; ovl = 0;
      forever begin
        @(negedge clk);
        if (busy[g] === 1'b1 && frdy[g] === 1'b1) ovl++;
        if (rst) begin
          drdy = 1'b1; cnt = 0; last_raise = -1; gmin = 1000; gmax = -1;
        end else begin
          if (fov[g] === 1'b1) begin
            nvalid++;
            last_raise = -1;
            last_gmin = gmin; last_gmax = gmax;
            gmin = 1000; gmax = -1;
          end
          if (cnt > 0) begin
            if (ddin[g] !== word) stab_viol++;
            cnt--;
            if (cnt == 0) begin
              drdy = 1'b1; ddout = ~word; last_raise = cyc; raise_any = cyc;
            end
          end else if (force_low[g]) begin
            drdy = 1'b0;
          end else begin
            drdy = 1'b1;
            if (dstart[g] === 1'b1) begin
              starts++;
              seen.push_back(ddin[g]);
              if (last_raise >= 0) begin
                gap = cyc - last_raise;
                if (gap < gmin) gmin = gap;
                if (gap > gmax) gmax = gap;
              end
              if (starts == ign_nth[g]) begin
                ign_cyc = cyc;
              end else begin
                word = ddin[g]; drdy = 1'b0; cnt = int'($urandom_range(4, 1));
              end
            end
          end
        end
      end
    end
  end

  // Reference: frame word i (MSW first), and the response after n words arrived.
  function automatic logic [DW-1:0] word_of(input logic [W-1:0] f, input int i);
    return f[W-1-i*DW -: DW];
  endfunction

  function automatic logic [W-1:0] exp_resp(input logic [W-1:0] f, input int n);
    logic [W-1:0] ones;
    ones = '1;
    if (n >= FWD) return ~f;
    return ~f & ~(ones >> (n * DW));
  endfunction

  task automatic wait_valid(input int g, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fov[g] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_frame(input int g, input logic [W-1:0] data, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (frdy[g] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      fin[g] = data;
      fv[g]  = 1'b1;
      @(negedge clk);
      fv[g]  = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (frdy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_frame_ready got=%b want=0", frdy[0]); end
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy[0]); end
    n_checks++; if (dstart[0] !== 1'b0) begin n_fail++; $display("FAIL reset_drv_start got=%b want=0", dstart[0]); end
    n_checks++; if (fov[0] !== 1'b0 || ferr[0] !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got=%b%b want=00", fov[0], ferr[0]); end
    n_checks++; if (fout[0] !== '0) begin n_fail++; $display("FAIL reset_frame_out got=%h want=0", fout[0]); end
    n_checks++; if (ddin[0] !== '0) begin n_fail++; $display("FAIL reset_drv_data_in got=%h want=0", ddin[0]); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (frdy[0] !== 1'b1 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL post_reset_ready got=%b/%b want=1/0", frdy[0], busy[0]); end
  endtask

  task automatic test_loopback();
    logic [W-1:0] f;
    int base, s0, v0;
    bit ok;
    f = 32'hA1B2C3D4;
    base = g_dut[0].seen.size(); s0 = g_dut[0].starts; v0 = g_dut[0].nvalid;
    send_frame(0, f, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL loopback_accept got=timeout want=accepted"); end
    wait_valid(0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL loopback_valid got=timeout want=pulse"); end
    n_checks++; if (fout[0] !== 32'h5E4D3C2B) begin n_fail++; $display("FAIL loopback_frame_out got=%h want=5e4d3c2b", fout[0]); end
    n_checks++; if (ferr[0] !== 1'b0) begin n_fail++; $display("FAIL loopback_err got=%b want=0", ferr[0]); end
    n_checks++; if (cyc !== g_dut[0].raise_any + 2) begin n_fail++; $display("FAIL loopback_valid_latency got=%0d want=%0d", cyc - g_dut[0].raise_any - 1, 1); end
    n_checks++; if (frdy[0] !== 1'b0) begin n_fail++; $display("FAIL loopback_ready_early got=%b want=0", frdy[0]); end
    @(negedge clk);
    n_checks++; if (frdy[0] !== 1'b1) begin n_fail++; $display("FAIL loopback_ready_return got=%b want=1", frdy[0]); end
    repeat (5) @(negedge clk);
    n_checks++; if (g_dut[0].nvalid - v0 != 1) begin n_fail++; $display("FAIL loopback_valid_count got=%0d want=1", g_dut[0].nvalid - v0); end
    n_checks++; if (g_dut[0].starts - s0 != FWD) begin n_fail++; $display("FAIL loopback_starts got=%0d want=%0d", g_dut[0].starts - s0, FWD); end
    for (int i = 0; i < FWD; i++) begin
      n_checks++;
      if (g_dut[0].seen.size() <= base + i) begin
        n_fail++; $display("FAIL loopback_word%0d got=missing want=%h", i, word_of(f, i));
      end else if (g_dut[0].seen[base+i] !== word_of(f, i)) begin
        n_fail++; $display("FAIL loopback_word%0d got=%h want=%h", i, g_dut[0].seen[base+i], word_of(f, i));
      end
    end
    n_checks++; if (g_dut[0].stab_viol != 0) begin n_fail++; $display("FAIL data_in_stable got=%0d changes want=0", g_dut[0].stab_viol); end
  endtask

  task automatic test_random();
    logic [W-1:0] f;
    int base;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      f = $urandom;
      base = g_dut[0].seen.size();
      send_frame(0, f, ok);
      wait_valid(0, ok);
      n_checks++; if (!ok || fout[0] !== exp_resp(f, FWD) || ferr[0] !== 1'b0) begin
        n_fail++; $display("FAIL random_frame%0d got=%h err=%b want=%h err=0", k, fout[0], ferr[0], exp_resp(f, FWD));
      end
      @(negedge clk);
      for (int i = 0; i < FWD; i++) begin
        n_checks++;
        if (g_dut[0].seen.size() <= base + i || g_dut[0].seen[base+i] !== word_of(f, i)) begin
          n_fail++; $display("FAIL random_word%0d_%0d want=%h", k, i, word_of(f, i));
        end
      end
    end
  endtask

  task automatic test_gap();
    int exp_gap[NI];
    bit ok;
    exp_gap[0] = 4; exp_gap[1] = 2; exp_gap[2] = 5;
    for (int g = 0; g < NI; g++) begin
      send_frame(g, $urandom, ok);
      wait_valid(g, ok);
      @(negedge clk);
      n_checks++;
      if (!ok || lgmin_w[g] != exp_gap[g] || lgmax_w[g] != exp_gap[g]) begin
        n_fail++; $display("FAIL gap_inst%0d got=%0d..%0d want=%0d", g, lgmin_w[g], lgmax_w[g], exp_gap[g]);
      end
    end
  endtask

  task automatic test_ready_low();
    logic [W-1:0] f;
    int s0, hi;
    bit ok;
    f = $urandom;
    force_low[0] = 1'b1;
    repeat (2) @(negedge clk);
    s0 = g_dut[0].starts;
    send_frame(0, f, ok);
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (dstart[0] !== 1'b0) hi++;
    end
    n_checks++; if (hi != 0) begin n_fail++; $display("FAIL ready_low_start got=%0d starts want=0", hi); end
    force_low[0] = 1'b0;
    wait_valid(0, ok);
    n_checks++; if (!ok || fout[0] !== exp_resp(f, FWD)) begin n_fail++; $display("FAIL ready_low_frame got=%h want=%h", fout[0], exp_resp(f, FWD)); end
    @(negedge clk);
    n_checks++; if (g_dut[0].starts - s0 != FWD) begin n_fail++; $display("FAIL ready_low_starts got=%0d want=%0d", g_dut[0].starts - s0, FWD); end
  endtask

  task automatic test_timeout();
    logic [W-1:0] f;
    int s0;
    bit ok;
    f = 32'hA1B2C3D4;
    s0 = g_dut[0].starts;
    ign_nth[0] = s0 + 2;
    send_frame(0, f, ok);
    wait_valid(0, ok);
    n_checks++; if (!ok || ferr[0] !== 1'b1) begin n_fail++; $display("FAIL timeout_err got=%b want=1", ferr[0]); end
    n_checks++; if (fout[0] !== exp_resp(f, 1)) begin n_fail++; $display("FAIL timeout_frame_out got=%h want=%h", fout[0], exp_resp(f, 1)); end
    n_checks++; if (cyc != g_dut[0].ign_cyc + TMO + 1) begin n_fail++; $display("FAIL timeout_latency got=%0d want=%0d", cyc - g_dut[0].ign_cyc, TMO + 1); end
    @(negedge clk);
    n_checks++; if (ferr[0] !== 1'b0 || fov[0] !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_width got=%b%b want=00", fov[0], ferr[0]); end
    n_checks++; if (g_dut[0].starts - s0 != 2) begin n_fail++; $display("FAIL timeout_starts got=%0d want=2", g_dut[0].starts - s0); end
    ign_nth[0] = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    send_frame(0, 32'hA5B6C7D8, ok);
    n = 0;
    for (int i = 0; i < 200 && n < 2; i++) begin
      @(posedge clk); #1;
      if (dstart[0] === 1'b1) n++;
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_checks++; if (n != 2 || frdy[0] !== 1'b0 || busy[0] !== 1'b0 || dstart[0] !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_ctrl got=%0d/%b%b%b want=2/000", n, frdy[0], busy[0], dstart[0]);
    end
    n_checks++; if (fout[0] !== '0 || fov[0] !== 1'b0 || ferr[0] !== 1'b0 || ddin[0] !== '0) begin
      n_fail++; $display("FAIL mid_reset_data got=%h/%b%b/%h want=0/00/0", fout[0], fov[0], ferr[0], ddin[0]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(0, 32'h01020304, ok);
    wait_valid(0, ok);
    n_checks++; if (!ok || fout[0] !== 32'hFEFDFCFB || ferr[0] !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_recover got=%h err=%b want=fefdfcfb err=0", fout[0], ferr[0]);
    end
  endtask

  task automatic test_valid_held();
    logic [W-1:0] f;
    int s0, vc, bad, rdy_cnt;
    f = $urandom;
    repeat (3) @(negedge clk);
    s0 = g_dut[0].starts; vc = 0; bad = 0; rdy_cnt = 0;
    fin[0] = f;
    fv[0]  = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (frdy[0] === 1'b1) rdy_cnt++;
      if (fov[0] === 1'b1) begin
        vc++;
        if (fout[0] !== exp_resp(f, FWD)) bad++;
      end
      if (vc == 3) break;
      @(negedge clk);
    end
    fv[0] = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (vc != 3 || bad != 0) begin n_fail++; $display("FAIL held_frames got=%0d bad=%0d want=3 bad=0", vc, bad); end
    n_checks++; if (rdy_cnt != 3) begin n_fail++; $display("FAIL held_ready_cycles got=%0d want=3", rdy_cnt); end
    n_checks++; if (g_dut[0].starts - s0 != 3 * FWD) begin n_fail++; $display("FAIL held_starts got=%0d want=%0d", g_dut[0].starts - s0, 3 * FWD); end
    n_checks++; if (ovl_w[0] + ovl_w[1] + ovl_w[2] != 0) begin n_fail++; $display("FAIL busy_ready_overlap got=%0d want=0", ovl_w[0] + ovl_w[1] + ovl_w[2]); end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      fv[i] = 1'b0; fin[i] = '0; force_low[i] = 1'b0; ign_nth[i] = 0;
    end
    #1 rst = 1'b1;
    test_reset();
    test_loopback();
    test_random();
    test_gap();
    test_ready_low();
    test_timeout();
    test_reset_mid();
    test_valid_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
